// File: rtl/brev_block_ctrl.sv
// brev_block_ctrl: collects DEPTH words per block into a bank of registers and
// drains them through one shared combinational bit-reversal stage.
//   Mode 0 reverses the whole DEPTH*WIDTH-bit block.
//   Mode 1 reverses each word and keeps word order.
// Optional feature, macro BREVCTRL_PINGPONG_EN: two banks, so one bank fills
// while the other drains. Without it there is a single bank, and the fill side
// stalls for the whole drain.
module brev_block_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InData,
    input  logic             InMode,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutData,
    output logic             OutLast,
    input  logic             Flush,
    output logic             Busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

`ifdef BREVCTRL_PINGPONG_EN
    localparam int NB = 2;
    localparam int MW = AW + 1;
`else
    localparam int NB = 1;
    localparam int MW = AW;
`endif

    // Bank storage, flattened as {bank, index}. Data is never reset.
    logic [WIDTH-1:0] mem [NB*DEPTH];

    logic [NB-1:0] full;
    logic [NB-1:0] mode;
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] rd_cnt;
    logic [AW-1:0] rd_idx;
    logic [MW-1:0] wr_addr;
    logic [MW-1:0] rd_addr;
    logic          wr_full;
    logic          rd_full;
    logic          rd_mode;
    logic          in_fire;
    logic          out_fire;

`ifdef BREVCTRL_PINGPONG_EN
    logic wr_bank;
    logic rd_bank;

    assign wr_full = full[wr_bank];
    assign rd_full = full[rd_bank];
    assign rd_mode = mode[rd_bank];
    assign wr_addr = {wr_bank, wr_cnt};
    assign rd_addr = {rd_bank, rd_idx};
`else
    assign wr_full = full[0];
    assign rd_full = full[0];
    assign rd_mode = mode[0];
    assign wr_addr = wr_cnt;
    assign rd_addr = rd_idx;
`endif

    // Mirror a word end to end: bit i lands at bit WIDTH-1-i.
    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[WIDTH-1-i] = x[i];
        end
        return r;
    endfunction

    // Block reversal reads the entries from the top down. DEPTH is a power of
    // two, so DEPTH-1-rd_cnt is simply the bitwise complement of rd_cnt.
    assign rd_idx = rd_mode ? rd_cnt : ~rd_cnt;

    // A Flush cycle discards any handshake that would otherwise happen.
    assign in_fire  = InValid && !wr_full && !Flush;
    assign out_fire = OutReady && rd_full && !Flush;

    // Handshake outputs and the shared reversal stage; OutData is zero when idle.
    always_comb begin
        InReady  = !wr_full;
        OutValid = rd_full;
        OutLast  = rd_full && (rd_cnt == LAST_IDX);
        OutData  = rd_full ? bit_rev(mem[rd_addr]) : '0;
        Busy     = (|full) || (wr_cnt != '0);
    end

    // Counters, Full flags, per-bank mode and bank pointers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            full    <= '0;
            mode    <= '0;
`ifdef BREVCTRL_PINGPONG_EN
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
`endif
        end else if (Flush) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            full    <= '0;
            mode    <= '0;
`ifdef BREVCTRL_PINGPONG_EN
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
`endif
        end else begin
            // Fill and drain never touch the same bank in one cycle: filling
            // needs that bank empty, draining needs it full.
            if (in_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
`ifdef BREVCTRL_PINGPONG_EN
                if (wr_cnt == '0) begin
                    mode[wr_bank] <= InMode;
                end
                if (wr_cnt == LAST_IDX) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
`else
                if (wr_cnt == '0) begin
                    mode[0] <= InMode;
                end
                if (wr_cnt == LAST_IDX) begin
                    full[0] <= 1'b1;
                end
`endif
            end
            if (out_fire) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_cnt == LAST_IDX) begin
`ifdef BREVCTRL_PINGPONG_EN
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
`else
                    full[0] <= 1'b0;
`endif
                end
            end
        end
    end

    // Capture accepted input words into the current fill bank.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem[wr_addr] <= InData;
        end
    end

endmodule

// File: tb/tb_brev_block_ctrl.sv
// tb_brev_block_ctrl: scoreboard bench for brev_block_ctrl (WIDTH=8, DEPTH=4).
// A monitor turns every accepted input block into expected output words, using
// a whole-block reference model, and compares them as the DUT drains.
module tb_brev_block_ctrl;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk      = 1'b0;
    logic         reset_n  = 1'b0;
    logic         InValid  = 1'b0;
    logic         InReady;
    logic [W-1:0] InData   = '0;
    logic         InMode   = 1'b0;
    logic         OutValid;
    logic         OutReady = 1'b0;
    logic [W-1:0] OutData;
    logic         OutLast;
    logic         Flush    = 1'b0;
    logic         Busy;

    brev_block_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .InValid  (InValid),
        .InReady  (InReady),
        .InData   (InData),
        .InMode   (InMode),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutData  (OutData),
        .OutLast  (OutLast),
        .Flush    (Flush),
        .Busy     (Busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } exp_t;

    // Monitor-owned state
    exp_t         exp_q[$];
    logic [W-1:0] part_q[$];
    logic         part_mode = 1'b0;
    logic [W-1:0] outlog[$];
    logic         lastlog[$];
    int           in_cyc[$];
    int           out_cyc[$];
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_d = '0;
    logic         prev_l = 1'b0;
    exp_t         e;
    int           n_cmp_s = 0;
    int           n_fail_s = 0;

    // Main-process state
    int           n_cmp_m = 0;
    int           n_fail_m = 0;
    int           cyc = 0;

    logic [W-1:0] ex1 [4] = '{8'h20, 8'hC0, 8'h40, 8'h80};
    logic [W-1:0] ex2 [4] = '{8'h80, 8'h40, 8'hC0, 8'h20};
    logic [W-1:0] ex4 [4] = '{8'h02, 8'h0C, 8'h04, 8'h08};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] rev_w(input logic [W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[W-1-i] = x[i];
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint expv);
        n_cmp_m++;
        if (act != expv) begin
            n_fail_m++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic chk_s(input string name, input longint act, input longint expv);
        n_cmp_s++;
        if (act != expv) begin
            n_fail_s++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: a finished block becomes D expected output words.
    task automatic model_block();
        logic [W*D-1:0] blk;
        logic [W*D-1:0] r;
        exp_t           x;
        for (int k = 0; k < D; k++) blk[k*W +: W] = part_q[k];
        for (int i = 0; i < W*D; i++) r[W*D-1-i] = blk[i];
        for (int k = 0; k < D; k++) begin
            x.d = part_mode ? rev_w(part_q[k]) : r[k*W +: W];
            x.l = (k == D-1);
            exp_q.push_back(x);
        end
        part_q.delete();
    endtask

    // Monitor: track accepted inputs, compare every output transfer, check holds
    always @(negedge clk) begin
        if (!reset_n || Flush) begin
            exp_q.delete();
            part_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk_s("hold_valid", OutValid, 1);
                chk_s("hold_data", OutData, prev_d);
                chk_s("hold_last", OutLast, prev_l);
            end
            if (OutValid && OutReady) begin
                if (exp_q.size() == 0) begin
                    n_cmp_s++;
                    n_fail_s++;
                    $display("FAIL unexpected_out: got 0x%0h, expected no output", OutData);
                end else begin
                    e = exp_q.pop_front();
                    chk_s("out_data", OutData, e.d);
                    chk_s("out_last", OutLast, e.l);
                end
                outlog.push_back(OutData);
                lastlog.push_back(OutLast);
                out_cyc.push_back(cyc);
            end
            prev_stall = OutValid && !OutReady;
            prev_d     = OutData;
            prev_l     = OutLast;
            if (InValid && InReady) begin
                if (part_q.size() == 0) part_mode = InMode;
                part_q.push_back(InData);
                in_cyc.push_back(cyc);
                if (part_q.size() == D) model_block();
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic m);
        int t = 0;
        InValid = 1'b1;
        InData  = d;
        InMode  = m;
        while (!InReady && t < 200) begin
            step();
            t++;
        end
        if (!InReady) begin
            n_cmp_m++;
            n_fail_m++;
            $display("FAIL send_timeout: InReady got 0, expected 1");
        end
        step();
        InValid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        OutReady = 1'b1;
        while ((Busy || OutValid) && t < 200) begin
            step();
            t++;
        end
        chk("idle_busy", Busy, 0);
    endtask

    task automatic check_block(input string name, input int base, input logic [W-1:0] ex [4]);
        chk({name, "_count"}, outlog.size() - base, D);
        if (outlog.size() - base == D) begin
            for (int k = 0; k < D; k++) begin
                chk({name, "_data"}, outlog[base+k], ex[k]);
                chk({name, "_last"}, lastlog[base+k], (k == D-1));
            end
        end
    endtask

    initial begin
        int base;
        int n;
        #2;
        chk("rst_outvalid", OutValid, 0);
        chk("rst_outlast", OutLast, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_inready", InReady, 1);
        chk("rst_outdata", OutData, 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        step();

        // Block reverse with latency check
        OutReady = 1'b1;
        base = outlog.size();
        for (int k = 0; k < 3; k++) send_word(W'(k + 1), 1'b0);
        chk("lat_before_last", OutValid, 0);
        send_word(8'h04, 1'b0);
        chk("lat_first_valid", OutValid, 1);
`ifndef BREVCTRL_PINGPONG_EN
        chk("inready_drain", InReady, 0);
`endif
        wait_idle();
        check_block("blkrev", base, ex1);

        // Per-word reverse
        base = outlog.size();
        for (int k = 0; k < D; k++) send_word(W'(k + 1), 1'b1);
        wait_idle();
        check_block("wordrev", base, ex2);

        // Backpressure mid-drain
        base = outlog.size();
        OutReady = 1'b0;
        for (int k = 0; k < D; k++) send_word(W'($urandom), 1'($urandom));
        step();
        OutReady = 1'b1;
        step();
        OutReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
`ifndef BREVCTRL_PINGPONG_EN
            chk("bp_inready", InReady, 0);
`endif
            chk("bp_valid", OutValid, 1);
            step();
        end
        wait_idle();
        chk("bp_count", outlog.size() - base, D);

        // Flush after two words, then a clean block
        send_word(W'($urandom), 1'b0);
        send_word(W'($urandom), 1'b0);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        chk("flush_busy", Busy, 0);
        chk("flush_inready", InReady, 1);
        chk("flush_outvalid", OutValid, 0);
        base = outlog.size();
        send_word(8'h10, 1'b0);
        send_word(8'h20, 1'b0);
        send_word(8'h30, 1'b0);
        send_word(8'h40, 1'b0);
        wait_idle();
        check_block("postflush", base, ex4);

        // Asynchronous reset mid-drain
        for (int k = 0; k < D; k++) send_word(W'($urandom), 1'b1);
        chk("arst_pre_valid", OutValid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_outvalid", OutValid, 0);
        chk("arst_outlast", OutLast, 0);
        chk("arst_busy", Busy, 0);
        chk("arst_inready", InReady, 1);
        chk("arst_outdata", OutData, 0);
        @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        chk("arst_rel_inready", InReady, 1);
        chk("arst_rel_busy", Busy, 0);
        step();

`ifdef BREVCTRL_PINGPONG_EN
        // Sustained back-to-back blocks; InMode only counts on each first word
        begin
            int ib;
            int ob;
            logic bm;
            ib = in_cyc.size();
            ob = out_cyc.size();
            OutReady = 1'b1;
            for (int i = 0; i < 3*D; i++) begin
                bm      = 1'((i / D) % 2);
                InValid = 1'b1;
                InData  = W'($urandom);
                InMode  = (i % D == 0) ? bm : ~bm;
                chk("pp_inready", InReady, 1);
                step();
            end
            InValid = 1'b0;
            wait_idle();
            chk("pp_out_count", out_cyc.size() - ob, 3*D);
            if (out_cyc.size() - ob == 3*D && in_cyc.size() - ib == 3*D) begin
                for (int k = 0; k < 3*D; k++)
                    chk("pp_out_cycle", out_cyc[ob+k], in_cyc[ib+D-1] + 1 + k);
            end
        end
`endif

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 600; i++) begin
            InValid  = ($urandom_range(9) < 7);
            InData   = W'($urandom);
            InMode   = 1'($urandom);
            OutReady = ($urandom_range(9) < 6);
            Flush    = ($urandom_range(49) == 0);
            step();
        end
        InValid = 1'b0;
        Flush   = 1'b0;
        n = part_q.size();
        if (n != 0) begin
            for (int k = n; k < D; k++) send_word(W'($urandom), 1'($urandom));
        end
        wait_idle();
        step();
        chk("final_exp_empty", exp_q.size(), 0);
        chk("final_partial", part_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp_m + n_cmp_s, n_fail_m + n_fail_s);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/brev_block_ctrl.md
Name: brev_block_ctrl

Overview:
- Sequencer that streams WIDTH-bit words through one shared combinational bit-reversal stage, block-wise.
- Gathers DEPTH words into a block buffer, then drains them bit-reversed.
- Mode 0 reverses the whole DEPTH*WIDTH-bit block. Mode 1 reverses each word with order kept.
- Sits between a BMU-side producer and a memory/consumer port; both sides use valid/ready handshakes.

Parameters:
- WIDTH, 32, word width in bits.
- DEPTH, 4, words per block; power of two, >=2.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- InValid  input  1  producer word valid
- InReady  output  1  controller can accept word
- InData  input  WIDTH  input word; word 0 of a block is least significant
- InMode  input  1  0 = block reverse, 1 = per-word reverse; sampled with the block's first word
- OutValid  output  1  output word valid
- OutReady  input  1  consumer accepts word
- OutData  output  WIDTH  reversed output word
- OutLast  output  1  high with the last word of a block
- Flush  input  1  synchronous abort of all buffered data
- Busy  output  1  any bank holds data or a fill is in progress

Behaviour:
- Reset: one clock, clk. reset_n is asynchronous and active-low.
  - Reset clears all counters and bank Full flags, sets WrBank=RdBank=0.
  - Output values during reset: OutValid=0, OutLast=0, Busy=0, InReady=1, OutData=0.
- Storage: NB banks of DEPTH x WIDTH registers. NB=1 by default, 2 with the optional feature.
  - Each bank has a Full flag and a stored Mode bit.
- Fill side:
  - InReady = !Full[WrBank].
  - An input transfer is InValid && InReady. It writes Bank[WrBank][WrCnt] and increments WrCnt (log2 DEPTH bits).
  - On the transfer with WrCnt==0, InMode is latched into that bank.
  - On the transfer with WrCnt==DEPTH-1: WrCnt wraps to 0, Full[WrBank] is set, and WrBank toggles (NB=2).
- Drain side:
  - OutValid = Full[RdBank].
  - Read index: Mode 0 reads index DEPTH-1-RdCnt; Mode 1 reads index RdCnt.
  - OutData = bit-reverse of the selected entry: OutData[WIDTH-1-i] = entry[i].
  - OutLast = OutValid && RdCnt==DEPTH-1.
  - An output transfer is OutValid && OutReady. It increments RdCnt.
  - On the last transfer: RdCnt wraps to 0, Full[RdBank] clears, and RdBank toggles (NB=2).
- Latency: first output word is valid the cycle after the block's last input transfer.
- Output hold: while OutValid && !OutReady, OutData and OutLast stay stable.
- Simultaneous events:
  - A fill transfer and a drain transfer in the same cycle on different banks are both honoured.
  - Drain completion frees a bank; the fill side sees InReady=1 in the next cycle, not combinationally.
- Flush:
  - Highest priority. Any handshake in the Flush cycle is discarded.
  - Next cycle: all Full=0, counters=0, banks=0, OutValid=0. Buffered contents become don't-care.
- Busy = |Full || WrCnt!=0.
- Reset mid-operation: immediate return to the reset state; the partial block is lost.
- Defined states per bank: EMPTY (Full=0, not writing), FILLING (WrBank, WrCnt>0), FULL (Full=1, draining).

Optional Feature:
- Macro: BREVCTRL_PINGPONG_EN.
- Defined: NB=2. Bank B can fill while bank A drains, giving sustained 1 word/cycle with no input bubbles.
- Undefined: NB=1, WrBank/RdBank are tied to 0.
  - InReady is low for the whole drain, so throughput is DEPTH words per 2*DEPTH cycles.

Test Plan:
- Block reverse (WIDTH=8, DEPTH=4, Mode 0): input 0x01,0x02,0x03,0x04 -> output 0x20,0xC0,0x40,0x80; OutLast only on 0x80; first OutValid the cycle after the 4th input transfer.
- Per-word reverse (Mode 1): input 0x01,0x02,0x03,0x04 -> output 0x80,0x40,0xC0,0x20.
- Backpressure: OutReady held low 3 cycles mid-drain -> OutData/OutLast stable, no word lost or duplicated; InReady=0 throughout (feature off).
- Flush after 2 input words -> next cycle Busy=0, InReady=1; a following block 0x10,0x20,0x30,0x40 (Mode 0) outputs 0x02,0x0C,0x04,0x08.
- Reset_n asserted asynchronously mid-drain -> OutValid falls without a clock edge; after release, InReady=1 and Busy=0.
- BREVCTRL_PINGPONG_EN, OutReady=1: 12 back-to-back input words -> InReady never drops; 12 outputs in 12 consecutive cycles starting the cycle after word 4; Mode latched independently per block.
